// File: rtl/crc32_pkg.sv
// crc32_pkg
// Shared CRC-32 definitions for the streaming checker.
//   CRC32_POLY   : generator polynomial 0x04C11DB7 (non-reflected form)
//   CRC32_SEED   : initial register value 0xFFFFFFFF
//   CRC32_MAX_DW : widest beat crc32_step accepts
//   crc32_t      : 32-bit CRC value type
//   crc32_step() : advances a CRC over the low nbits of data, MSB first
// No final XOR and no bit reflection are applied anywhere.
package crc32_pkg;

    localparam int CRC32_MAX_DW = 1024;

    typedef logic [31:0] crc32_t;

    localparam crc32_t CRC32_POLY = 32'h04C1_1DB7;
    localparam crc32_t CRC32_SEED = 32'hFFFF_FFFF;

    // data carries the beat zero-extended in its low nbits. Bits above nbits
    // are skipped, so a constant nbits folds the loop to pure XOR logic.
    function automatic crc32_t crc32_step(input crc32_t                  crc,
                                          input logic [CRC32_MAX_DW-1:0] data,
                                          input int                      nbits);
        crc32_t c;
        logic   fb;
        c = crc;
        for (int i = CRC32_MAX_DW - 1; i >= 0; i--) begin
            if (i < nbits) begin
                fb = c[31] ^ data[i];
                c  = {c[30:0], 1'b0};
                if (fb) begin
                    c = c ^ CRC32_POLY;
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_stream_acc.sv
// crc32_stream_acc
// Frame-level CRC accumulator: frame FSM, running CRC, beat counter and
// sticky length-error flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   beat_i     : a beat is accepted this cycle
//   data_i     : beat payload
//   last_i     : beat closes the frame
//   first_o    : next accepted beat opens a frame
//   crc_nxt_o  : CRC including the current beat (valid while beat_i)
//   len_err_o  : frame is over length, including this beat
//
// state   | meaning
// S_FIRST | idle / between frames; next beat is seeded with CRC32_SEED
// S_BODY  | inside a multi-beat frame; next beat continues crc_q
module crc32_stream_acc
    import crc32_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int MAX_BEATS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    output logic                  first_o,
    output crc32_t                crc_nxt_o,
    output logic                  len_err_o
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    localparam logic [0:0] S_FIRST = 1'b0;
    localparam logic [0:0] S_BODY  = 1'b1;

    logic [0:0]          state_q, state_d;
    crc32_t              crc_q;
    logic [BW-1:0]       beat_q, beat_d;
    logic                len_err_q, len_err_d;
    logic                len_err_now;
    logic [CRC32_MAX_DW-1:0] data_ext;

    assign data_ext    = CRC32_MAX_DW'(data_i);
    assign first_o     = (state_q == S_FIRST);
    assign crc_nxt_o   = crc32_step(first_o ? CRC32_SEED : crc_q, data_ext, DATA_WIDTH);
    assign len_err_now = (beat_q == BW'(MAX_BEATS - 1)) && !last_i;
    assign len_err_o   = len_err_q || len_err_now;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        len_err_d = len_err_q;
        if (beat_i) begin
            if (last_i) begin
                state_d   = S_FIRST;
                beat_d    = '0;
                len_err_d = 1'b0;
            end else begin
                state_d   = S_BODY;
                len_err_d = len_err_q || len_err_now;
                if (beat_q != BW'(MAX_BEATS)) begin
                    beat_d = beat_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FIRST;
            crc_q     <= CRC32_SEED;
            beat_q    <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            len_err_q <= len_err_d;
            if (beat_i) begin
                crc_q <= crc_nxt_o;
            end
        end
    end

endmodule

// File: rtl/crc32_stream_chk.sv
// crc32_stream_chk
// Multi-beat CRC-32 checker with a single registered valid/ready stage.
//   clk, rst_n           : clock, asynchronous active-low reset
//   valid_i/ready_o      : input handshake
//   data_i, last_i       : input beat and end-of-frame marker
//   checksum_i           : received CRC, sampled on the accepted last beat
//   valid_o/ready_i      : output handshake
//   data_o, last_o       : registered copy of the accepted beat
//   detected_o           : on a last output beat, 1 = CRC or length error
//   err_cnt_o            : saturating errored-frame count (only when
//                          CRC32_STREAM_ERR_CNT_EN is defined)
module crc32_stream_chk
    import crc32_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int CRC_WIDTH  = 32,
    parameter int MAX_BEATS  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic [CRC_WIDTH-1:0]  checksum_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
`ifdef CRC32_STREAM_ERR_CNT_EN
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
`endif
    output logic                  detected_o
);

    if (CRC_WIDTH != 32) begin : g_bad_crc_width
        $error("crc32_stream_chk: CRC_WIDTH must be 32");
    end
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > CRC32_MAX_DW) begin : g_bad_data_width
        $error("crc32_stream_chk: DATA_WIDTH must be a multiple of 8 within crc32_step range");
    end
    if (MAX_BEATS < 1) begin : g_bad_max_beats
        $error("crc32_stream_chk: MAX_BEATS must be at least 1");
    end

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q;
    logic                  det_q;
    logic                  accept;
    logic                  first;
    crc32_t                crc_nxt;
    logic                  len_err;
    logic                  detected_n;

    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o;

    crc32_stream_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BEATS  (MAX_BEATS)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_i    (accept),
        .data_i    (data_i),
        .last_i    (last_i),
        .first_o   (first),
        .crc_nxt_o (crc_nxt),
        .len_err_o (len_err)
    );

    // Non-last beats never report an error, so detected_o needs no qualifier.
    assign detected_n = last_i && ((crc_nxt != checksum_i) || len_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            det_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
            det_q   <= detected_n;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign last_o     = last_q;
    assign detected_o = det_q;

`ifdef CRC32_STREAM_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (valid_q && ready_i && last_q && det_q && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    // first is only needed inside the accumulator in this build.
    logic unused_first;
    assign unused_first = first;
`endif

endmodule

// File: tb/tb_crc32_stream_chk.sv
module tb_crc32_stream_chk;

    localparam int DW = 64;
    localparam int MB = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_i;
    logic          last_i;
    logic [31:0]   checksum_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          detected_o;
`ifdef CRC32_STREAM_ERR_CNT_EN
    logic [CW-1:0] err_cnt_o;
`endif

    crc32_stream_chk #(
        .DATA_WIDTH (DW),
        .CRC_WIDTH  (32),
        .MAX_BEATS  (MB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .last_i     (last_i),
        .checksum_i (checksum_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .last_o     (last_o),
`ifdef CRC32_STREAM_ERR_CNT_EN
        .err_cnt_o  (err_cnt_o),
`endif
        .detected_o (detected_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          det;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [31:0]   chk;
        logic          exp_det;
    } vec_t;

    int    checks   = 0;
    int    failures = 0;
    int    exp_cnt  = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    // Reference CRC over the whole frame as one bit string, beats in order.
    function automatic logic [31:0] ref_crc(input logic [DW-1:0] beats[8], input int n);
        logic [31:0] r;
        logic        b;
        r = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++) begin
            for (int j = DW - 1; j >= 0; j--) begin
                b = beats[k][j];
                if (r[31] != b) r = (r << 1) ^ 32'h04C1_1DB7;
                else            r = r << 1;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] crc1(input logic [DW-1:0] d);
        logic [DW-1:0] bb[8];
        for (int k = 0; k < 8; k++) bb[k] = '0;
        bb[0] = d;
        return ref_crc(bb, 1);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output monitor: a beat is taken downstream when valid_o && ready_i.
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            obs_q.push_back('{data: data_o, last: last_o, det: detected_o});
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic [31:0] c,
                             input logic exp_det);
        int n;
        valid_i    = 1'b1;
        data_i     = d;
        last_i     = l;
        checksum_i = c;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: ready_o stuck at %b required 1", ready_o);
                break;
            end
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        exp_q.push_back('{data: d, last: l, det: exp_det});
        if (l && exp_det) exp_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        beat_t e, o;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle(2);
        check({name, "_count"}, DW'(obs_q.size()), DW'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({name, "_data"}, o.data, e.data);
            check({name, "_last"}, DW'(o.last), DW'(e.last));
            check({name, "_det"},  DW'(o.det),  DW'(e.det));
        end
        exp_q.delete();
        obs_q.delete();
`ifdef CRC32_STREAM_ERR_CNT_EN
        check({name, "_err_cnt"}, DW'(err_cnt_o), DW'(exp_cnt));
`endif
    endtask

    // n-beat frame of pattern beats; bad flips checksum; gaps inserts idles.
    task automatic send_frame(input logic [DW-1:0] beats[8], input int n, input logic bad,
                              input logic exp_det, input int gap_after);
        logic [31:0] c;
        c = ref_crc(beats, n) ^ (bad ? 32'h0000_0001 : 32'h0);
        for (int k = 0; k < n; k++) begin
            send_beat(beats[k], k == n - 1, (k == n - 1) ? c : 32'hDEAD_BEEF,
                      (k == n - 1) ? exp_det : 1'b0);
            if (k < gap_after) idle(2);
        end
    endtask

    vec_t          vecs[6];
    logic [DW-1:0] fb[8];
    logic [DW-1:0] s1, s2, s3;
    logic [31:0]   known;

    initial begin
        rst_n      = 1'b0;
        valid_i    = 1'b0;
        data_i     = '0;
        last_i     = 1'b0;
        checksum_i = '0;
        ready_i    = 1'b1;

        // CRC-32/MPEG-2 check value of "123456789" anchors the reference model.
        begin
            logic [71:0] msg;
            msg   = "123456789";
            known = 32'hFFFF_FFFF;
            for (int j = 71; j >= 0; j--) begin
                if (known[31] != msg[j]) known = (known << 1) ^ 32'h04C1_1DB7;
                else                     known = known << 1;
            end
            check("model_check_value", DW'(known), DW'(32'h0376_E6E7));
        end

        vecs[0] = '{data: 64'h0,                     chk: crc1(64'h0),                     exp_det: 1'b0};
        vecs[1] = '{data: 64'h1,                     chk: crc1(64'h0),                     exp_det: 1'b1};
        vecs[2] = '{data: 64'hDEAD_BEEF_0123_4567,   chk: crc1(64'hDEAD_BEEF_0123_4567),   exp_det: 1'b0};
        vecs[3] = '{data: 64'hDEAD_BEEF_0123_4567,   chk: crc1(64'hDEAD_BEEF_0123_4567) ^ 32'h8000_0000, exp_det: 1'b1};
        vecs[4] = '{data: 64'hFFFF_FFFF_FFFF_FFFF,   chk: crc1(64'hFFFF_FFFF_FFFF_FFFF),   exp_det: 1'b0};
        vecs[5] = '{data: 64'h8000_0000_0000_0000,   chk: ~crc1(64'h8000_0000_0000_0000),  exp_det: 1'b1};

        #23;
        check("reset_valid_o",    DW'(valid_o),    DW'(0));
        check("reset_last_o",     DW'(last_o),     DW'(0));
        check("reset_detected_o", DW'(detected_o), DW'(0));
        check("reset_data_o",     data_o,          DW'(0));
        check("reset_ready_o",    DW'(ready_o),    DW'(1));
`ifdef CRC32_STREAM_ERR_CNT_EN
        check("reset_err_cnt_o",  DW'(err_cnt_o),  DW'(0));
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Single-beat frames; first one checks the one-cycle latency directly.
        valid_i = 1'b1; data_i = vecs[0].data; last_i = 1'b1; checksum_i = vecs[0].chk;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check("lat_valid_o", DW'(valid_o),    DW'(1));
        check("lat_last_o",  DW'(last_o),     DW'(1));
        check("lat_det_o",   DW'(detected_o), DW'(0));
        idle(2);
        obs_q.delete();

        for (int i = 0; i < 6; i++) begin
            send_beat(vecs[i].data, 1'b1, vecs[i].chk, vecs[i].exp_det);
            idle(1);
        end
        drain("single");

        // Back-to-back single-beat frames, no idle between them.
        for (int i = 0; i < 4; i++) send_beat(vecs[i].data, 1'b1, vecs[i].chk, vecs[i].exp_det);
        drain("b2b");

        // 4-beat frame with valid_i gaps after beats 1 and 2: length limit exactly met.
        for (int k = 0; k < 8; k++) fb[k] = {8{8'(k + 1)}};
        send_frame(fb, 4, 1'b0, 1'b0, 2);
        drain("four_beat");
        send_frame(fb, 3, 1'b1, 1'b1, 0);
        drain("three_bad");

        // Downstream stall of 5 cycles mid-frame.
        s1 = 64'h1111_2222_3333_4444;
        s2 = 64'h5555_6666_7777_8888;
        s3 = 64'h9999_AAAA_BBBB_CCCC;
        for (int k = 0; k < 8; k++) fb[k] = '0;
        fb[0] = s1; fb[1] = s2; fb[2] = s3;
        send_beat(s1, 1'b0, 32'h0, 1'b0);
        ready_i    = 1'b0;
        valid_i    = 1'b1;
        data_i     = s2;
        last_i     = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid_o", DW'(valid_o), DW'(1));
            check("stall_data_o",  data_o,       s1);
            check("stall_last_o",  DW'(last_o),  DW'(0));
            check("stall_ready_o", DW'(ready_o), DW'(0));
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        exp_q.push_back('{data: s2, last: 1'b0, det: 1'b0});
        send_beat(s3, 1'b1, ref_crc(fb, 3), 1'b0);
        drain("stall");

        // Over-length: 6 beats with a correct CRC still flag, then a good frame clears.
        for (int k = 0; k < 8; k++) fb[k] = {4{16'(16'hA000 + k)}};
        send_frame(fb, 6, 1'b0, 1'b1, 0);
        drain("six_beat");
        send_frame(fb, 5, 1'b0, 1'b1, 0);
        drain("five_beat");
        send_frame(fb, 2, 1'b0, 1'b0, 0);
        drain("after_len");

        // Reset after beat 2 of a 3-beat frame discards it.
        for (int k = 0; k < 8; k++) fb[k] = {8{8'(8'h30 + k)}};
        send_beat(fb[0], 1'b0, 32'h0, 1'b0);
        send_beat(fb[1], 1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_valid_o", DW'(valid_o),    DW'(0));
        check("mrst_last_o",  DW'(last_o),     DW'(0));
        check("mrst_det_o",   DW'(detected_o), DW'(0));
        check("mrst_data_o",  data_o,          DW'(0));
        exp_q.delete();
        obs_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send_beat(fb[2], 1'b1, crc1(fb[2]), 1'b0);
        drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded limit");
        $fatal(1, "timeout");
    end

endmodule
